int_prio_ctrl: RTL and testbench
================================

// Module: int_prio_ctrl
// PURPOSE
//  8051 interrupt controller: owns IE (0xA8) and IP (0xB8) SFRs, arbitrates EXT0/TIMR0/EXT1/TIMR1(/serial)
//  requests by two-level priority, hands one vector to the CPU core and returns the IACK_* pulses that
//  clear the TCON flags in timer_cntr01. Tracks in-service levels for nesting and RETI.
// PARAMETERS
//  IE_ADDRESS   8'hA8  direct address of IE
//  IP_ADDRESS   8'hB8  direct address of IP
//  HOLDOFF      2      cycles INT_REQ stays low after IACK / RETI / IE-IP write (min 1)
// PORTS
//  CPUClock      in   1   core clock, all state on rising edge
//  RESET_N       in   1   synchronous active-low reset
//  DIR_RD_ADDRS  in   8   SFR read address
//  DIR_WR_ADDRS  in   8   SFR write address
//  WR_DATA       in   8   SFR write data
//  WR_EN         in   1   write enable (qualified with DIRECT_WR)
//  DIRECT_WR     in   1   direct-address write
//  RD_DATA       out  8   IE / IP read data, 8'h00 for other addresses (combinational)
//  IE0_IN        in   1   TCON[1] ext0 flag
//  TF0_IN        in   1   TCON[5] timer0 flag (TIMR0_INT_REQ)
//  IE1_IN        in   1   TCON[3] ext1 flag
//  TF1_IN        in   1   TCON[7] timer1 flag (TIMR1_INT_REQ)
//  SER_INT_IN    in   1   RI|TI (only with IRQ_SERIAL_EN)
//  INT_TAKEN     in   1   1-cycle pulse: core has begun the vectored LCALL
//  RETI          in   1   1-cycle pulse: core executed RETI
//  INT_REQ       out  1   interrupt pending to core
//  INT_VECTOR    out  16  target address, valid while INT_REQ=1
//  IACK_EXT0 / IACK_TIMR0 / IACK_EXT1 / IACK_TIMR1  out 1 each  1-cycle flag-clear pulses
// BEHAVIOUR
//  - Reset: IE=00, IP=00, INT_REQ=0, INT_VECTOR=0000, all IACK_*=0, in-service bits IS_LO=IS_HI=0, holdoff=0.
//  - SFR write: addr match & WR_EN & DIRECT_WR, takes effect next edge; IE[6:5], IP[7:5] unwritable, read 0.
//  - Eligible src = flag & IE[bit] & IE[7](EA). Level = IP[bit]. Bits: EXT0 0, TIMR0 1, EXT1 2, TIMR1 3, SER 4.
//  - Winner: highest level first, then fixed order EXT0>TIMR0>EXT1>TIMR1>SER.
//  - Vectors: EXT0 0003, TIMR0 000B, EXT1 0013, TIMR1 001B, SER 0023.
//  - Admission: high-level winner admitted if IS_HI=0; low-level winner admitted if IS_LO=0 and IS_HI=0.
//  - FSM IDLE -> PEND -> ACK -> IDLE (registered outputs):
//    IDLE: admitted winner & holdoff=0 -> PEND; INT_REQ=1 and INT_VECTOR loaded at that edge (1-cycle latency
//      from flag to INT_REQ).
//    PEND: re-arbitrates every cycle; INT_VECTOR may change to a better winner; if no admitted winner remains
//      (flag dropped, IE cleared) -> IDLE, INT_REQ=0. INT_TAKEN -> ACK, latched source = current INT_VECTOR.
//    ACK: INT_REQ=0; matching IACK_* high exactly this cycle (none for SER); set IS_HI or IS_LO per latched
//      level; load holdoff=HOLDOFF; -> IDLE.
//  - Holdoff decrements to 0 per cycle; reloaded by ACK, RETI, IE/IP write. Ensures cleared flag not re-taken.
//  - RETI: clears IS_HI if set, else IS_LO; RETI with both clear is ignored.
//  - RETI and INT_TAKEN same cycle: RETI pop applied first, then transition to ACK; push in ACK.
//  - INT_TAKEN while not in PEND: ignored, no IACK.
//  - IE/IP write during PEND: new values used in same-cycle re-arbitration of next edge.
//  - Reset mid-operation (any state): returns to IDLE, in-service cleared, pending IACK suppressed.
// CONFIGURATION
//  - IRQ_SERIAL_EN defined: SER_INT_IN port, IE[4]/IP[4] writable, vector 0023 arbitrated, no IACK (software clears RI/TI).
//  - Not defined: SER_INT_IN absent, IE[4]/IP[4] read 0, writes ignored, four sources only.
// TESTING
//  - Reset, IE=8'h82, TF0_IN=1 -> INT_REQ=1/VECTOR=000B next cycle; INT_TAKEN -> IACK_TIMR0 one cycle, INT_REQ=0 >=2 cycles.
//  - IE=8'h8F, IP=00, all four flags same cycle -> VECTOR=0003; after ack+clear next is 000B, then 0013, 001B.
//  - IP=8'h08, IS_LO set (in EXT0 ISR), TF1_IN=1 -> preempts, VECTOR=001B; IS_HI set; EXT1 request blocked until two RETIs.
//  - IS_HI set, low IE0_IN=1 -> INT_REQ stays 0; RETI -> INT_REQ=1 VECTOR=0003 after holdoff expires.
//  - In PEND for 0013, clear IE[2] via SFR write -> INT_REQ=0 next cycle, no IACK; EA=0 masks all.
//  - RESET_N=0 during ACK -> no IACK pulse, IE/IP=00, RD_DATA at 0xA8 reads 00; serial vector 0023 with IRQ_SERIAL_EN only.

Source files
------------

// File: rtl/int_prio_ctrl.sv
// 8051 interrupt controller: IE/IP SFRs, two-level priority arbitration, vector hand-off, IACK pulses, nesting.
// Optional serial source enabled by defining IRQ_SERIAL_EN.
module int_prio_ctrl #(
    parameter logic [7:0]  IE_ADDRESS = 8'hA8,
    parameter logic [7:0]  IP_ADDRESS = 8'hB8,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic        CPUClock,
    input  logic        RESET_N,
    input  logic [7:0]  DIR_RD_ADDRS,
    input  logic [7:0]  DIR_WR_ADDRS,
    input  logic [7:0]  WR_DATA,
    input  logic        WR_EN,
    input  logic        DIRECT_WR,
    output logic [7:0]  RD_DATA,
    input  logic        IE0_IN,
    input  logic        TF0_IN,
    input  logic        IE1_IN,
    input  logic        TF1_IN,
`ifdef IRQ_SERIAL_EN
    input  logic        SER_INT_IN,
`endif
    input  logic        INT_TAKEN,
    input  logic        RETI,
    output logic        INT_REQ,
    output logic [15:0] INT_VECTOR,
    output logic        IACK_EXT0,
    output logic        IACK_TIMR0,
    output logic        IACK_EXT1,
    output logic        IACK_TIMR1
);

`ifdef IRQ_SERIAL_EN
    localparam int         NSRC    = 5;
    localparam logic [7:0] IE_MASK = 8'h9F;
    localparam logic [7:0] IP_MASK = 8'h1F;
`else
    localparam int         NSRC    = 4;
    localparam logic [7:0] IE_MASK = 8'h8F;
    localparam logic [7:0] IP_MASK = 8'h0F;
`endif
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]      state_reg;
    logic [7:0]      ie_reg, ip_reg, ie_next, ip_next;
    logic            ie_wr, ip_wr;
    logic            is_hi_reg, is_lo_reg, is_hi_next, is_lo_next;
    logic [HW-1:0]   holdoff_reg;
    logic            reload;
    logic            int_req_reg;
    logic [15:0]     vector_reg;
    logic [2:0]      cur_src_reg;
    logic            cur_lvl_reg;
    logic [3:0]      iack_reg, iack_dec;
    logic [NSRC-1:0] flag_vec, elig, hi_req, lo_req;
    logic [2:0]      win_idx;
    logic            win_hi, admitted;
    logic [15:0]     win_vector;

    assign ie_wr   = WR_EN & DIRECT_WR & (DIR_WR_ADDRS == IE_ADDRESS);
    assign ip_wr   = WR_EN & DIRECT_WR & (DIR_WR_ADDRS == IP_ADDRESS);
    assign ie_next = ie_wr ? (WR_DATA & IE_MASK) : ie_reg;
    assign ip_next = ip_wr ? (WR_DATA & IP_MASK) : ip_reg;

    assign flag_vec[3:0] = {TF1_IN, IE1_IN, TF0_IN, IE0_IN};
`ifdef IRQ_SERIAL_EN
    assign flag_vec[4] = SER_INT_IN;
`endif

    // Arbitration sees a same-cycle SFR write so a masked source drops out at the very next edge.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign elig[gi]   = flag_vec[gi] & ie_next[gi] & ie_next[7];
            assign hi_req[gi] = elig[gi] & ip_next[gi];
            assign lo_req[gi] = elig[gi] & ~ip_next[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_iack
            assign iack_dec[gi] = (cur_src_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        win_idx = 3'd0;
        win_hi  = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (lo_req[i]) win_idx = 3'(i);
        end
        if (|hi_req) begin
            win_hi = 1'b1;
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (hi_req[i]) win_idx = 3'(i);
            end
        end
    end

    assign admitted   = win_hi ? ~is_hi_reg : (|lo_req & ~is_hi_reg & ~is_lo_reg);
    assign win_vector = {10'd0, win_idx, 3'b011};
    assign reload     = (state_reg == ST_ACK) | RETI | ie_wr | ip_wr;

    // RETI pops before the ACK push so a coincident return and entry nest correctly.
    always_comb begin
        is_hi_next = is_hi_reg;
        is_lo_next = is_lo_reg;
        if (RETI) begin
            if (is_hi_reg) is_hi_next = 1'b0;
            else           is_lo_next = 1'b0;
        end
        if (state_reg == ST_ACK) begin
            if (cur_lvl_reg) is_hi_next = 1'b1;
            else             is_lo_next = 1'b1;
        end
    end

    always_ff @(posedge CPUClock) begin
        if (!RESET_N) begin
            state_reg   <= ST_IDLE;
            ie_reg      <= 8'h00;
            ip_reg      <= 8'h00;
            is_hi_reg   <= 1'b0;
            is_lo_reg   <= 1'b0;
            holdoff_reg <= '0;
            int_req_reg <= 1'b0;
            vector_reg  <= 16'h0000;
            cur_src_reg <= 3'd0;
            cur_lvl_reg <= 1'b0;
            iack_reg    <= 4'd0;
        end else begin
            ie_reg    <= ie_next;
            ip_reg    <= ip_next;
            is_hi_reg <= is_hi_next;
            is_lo_reg <= is_lo_next;
            iack_reg  <= 4'd0;
            if (reload)
                holdoff_reg <= HW'(HOLDOFF);
            else if (holdoff_reg != '0)
                holdoff_reg <= holdoff_reg - HW'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (admitted && (holdoff_reg == '0) && !reload) begin
                        state_reg   <= ST_PEND;
                        int_req_reg <= 1'b1;
                        vector_reg  <= win_vector;
                        cur_src_reg <= win_idx;
                        cur_lvl_reg <= win_hi;
                    end
                end
                ST_PEND: begin
                    if (INT_TAKEN) begin
                        state_reg   <= ST_ACK;
                        int_req_reg <= 1'b0;
                        iack_reg    <= iack_dec;
                    end else if (admitted) begin
                        vector_reg  <= win_vector;
                        cur_src_reg <= win_idx;
                        cur_lvl_reg <= win_hi;
                    end else begin
                        state_reg   <= ST_IDLE;
                        int_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        RD_DATA = 8'h00;
        if (DIR_RD_ADDRS == IE_ADDRESS)      RD_DATA = ie_reg;
        else if (DIR_RD_ADDRS == IP_ADDRESS) RD_DATA = ip_reg;
    end

    // A reset asserted during the ACK cycle must not leak a flag-clear pulse.
    assign IACK_EXT0  = iack_reg[0] & RESET_N;
    assign IACK_TIMR0 = iack_reg[1] & RESET_N;
    assign IACK_EXT1  = iack_reg[2] & RESET_N;
    assign IACK_TIMR1 = iack_reg[3] & RESET_N;
    assign INT_REQ    = int_req_reg;
    assign INT_VECTOR = vector_reg;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// Scoreboard bench for int_prio_ctrl: stimulus queues expected requests/IACKs, a negedge monitor compares them.
module tb_int_prio_ctrl;
    logic        CPUClock = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  DIR_RD_ADDRS = 8'h00, DIR_WR_ADDRS = 8'h00, WR_DATA = 8'h00;
    logic        WR_EN = 1'b0, DIRECT_WR = 1'b0, INT_TAKEN = 1'b0, RETI = 1'b0;
    logic [3:0]  flags = 4'h0;
    logic [7:0]  RD_DATA;
    logic        INT_REQ, IACK_EXT0, IACK_TIMR0, IACK_EXT1, IACK_TIMR1;
    logic [15:0] INT_VECTOR;
    logic [3:0]  iack_bus;
`ifdef IRQ_SERIAL_EN
    logic        ser_flag = 1'b0;
    localparam logic [7:0] IE_RB = 8'h9F;
    localparam logic [7:0] IP_RB = 8'h1F;
`else
    localparam logic [7:0] IE_RB = 8'h8F;
    localparam logic [7:0] IP_RB = 8'h0F;
`endif

    typedef struct packed { logic kind; logic [15:0] val; } ev_t;  // kind 0 = request, 1 = iack
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 CPUClock = ~CPUClock;
    assign iack_bus = {IACK_TIMR1, IACK_EXT1, IACK_TIMR0, IACK_EXT0};

    int_prio_ctrl dut (
        .CPUClock(CPUClock), .RESET_N(RESET_N),
        .DIR_RD_ADDRS(DIR_RD_ADDRS), .DIR_WR_ADDRS(DIR_WR_ADDRS), .WR_DATA(WR_DATA),
        .WR_EN(WR_EN), .DIRECT_WR(DIRECT_WR), .RD_DATA(RD_DATA),
        .IE0_IN(flags[0]), .TF0_IN(flags[1]), .IE1_IN(flags[2]), .TF1_IN(flags[3]),
`ifdef IRQ_SERIAL_EN
        .SER_INT_IN(ser_flag),
`endif
        .INT_TAKEN(INT_TAKEN), .RETI(RETI), .INT_REQ(INT_REQ), .INT_VECTOR(INT_VECTOR),
        .IACK_EXT0(IACK_EXT0), .IACK_TIMR0(IACK_TIMR0), .IACK_EXT1(IACK_EXT1), .IACK_TIMR1(IACK_TIMR1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic push_ev(input logic kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic compare_event(input logic kind, input logic [15:0] val, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %h expected nothing", name, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                errors++;
                $display("FAIL %s: got kind %0d value %h expected kind %0d value %h", name, kind, val, e.kind, e.val);
            end else
                $display("ok   %s: %h", name, val);
        end
    endtask

    // Monitor: every IACK pulse and every new request / vector change is one scoreboard transaction.
    initial begin
        logic        prev_req;
        logic [15:0] prev_vec;
        prev_req = 1'b0;
        prev_vec = 16'h0000;
        forever begin
            @(negedge CPUClock);
            if (iack_bus != 4'd0) compare_event(1'b1, {12'd0, iack_bus}, "iack");
            if (INT_REQ === 1'b1 && (!prev_req || INT_VECTOR !== prev_vec))
                compare_event(1'b0, INT_VECTOR, "req");
            prev_req = (INT_REQ === 1'b1);
            prev_vec = INT_VECTOR;
        end
    end

    task automatic step();
        @(posedge CPUClock);
        #1;
    endtask

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
        DIR_WR_ADDRS = addr; WR_DATA = data; WR_EN = 1'b1; DIRECT_WR = 1'b1;
        step();
        WR_EN = 1'b0; DIRECT_WR = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
        DIR_RD_ADDRS = addr;
        #1;
        check(name, {8'd0, RD_DATA}, {8'd0, exp});
    endtask

    task automatic pulse_reti();
        RETI = 1'b1;
        step();
        RETI = 1'b0;
    endtask

    task automatic take(input logic [3:0] iack_exp);
        if (iack_exp != 4'd0) push_ev(1'b1, {12'd0, iack_exp});
        INT_TAKEN = 1'b1;
        step();
        INT_TAKEN = 1'b0;
    endtask

    task automatic service(input int idx, input bit do_reti);
        logic [3:0] bits;
        bits = 4'd1 << idx;
        take(bits);
        flags[idx] = 1'b0;
        step();
        if (do_reti) pulse_reti();
    endtask

    task automatic wait_req(input string name, input logic [15:0] vec);
        int n;
        push_ev(1'b0, vec);
        n = 0;
        while (INT_REQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (INT_REQ !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: INT_REQ %b after 20 cycles, expected 1", name, INT_REQ);
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, {15'd0, INT_REQ}, 16'd0);
        end
    endtask

    initial begin
        repeat (3) step();
        RESET_N = 1'b1;
        step();
        check("rst_int_req", {15'd0, INT_REQ}, 16'd0);
        check("rst_vector", INT_VECTOR, 16'h0000);
        check("rst_iack", {12'd0, iack_bus}, 16'd0);
        read_check("rst_ie", 8'hA8, 8'h00);
        read_check("rst_ip", 8'hB8, 8'h00);
        read_check("rd_other", 8'h00, 8'h00);

        // Reserved bits stay zero; INT_TAKEN while idle produces nothing.
        sfr_write(8'hA8, 8'hFF);
        read_check("ie_mask", 8'hA8, IE_RB);
        sfr_write(8'hB8, 8'hFF);
        read_check("ip_mask", 8'hB8, IP_RB);
        sfr_write(8'hA8, 8'h00);
        sfr_write(8'hB8, 8'h00);
        take(4'd0);
        check("idle_taken_iack", {12'd0, iack_bus}, 16'd0);

        // Single timer0 request: 1-cycle latency, IACK, holdoff after RETI.
        sfr_write(8'hA8, 8'h82);
        repeat (3) step();
        flags[1] = 1'b1;
        #1 check("lat_pre", {15'd0, INT_REQ}, 16'd0);
        push_ev(1'b0, 16'h000B);
        step();
        check("lat_req", {15'd0, INT_REQ}, 16'd1);
        check("lat_vec", INT_VECTOR, 16'h000B);
        take(4'b0010);
        check("ack_req_low", {15'd0, INT_REQ}, 16'd0);
        expect_quiet("after_ack", 1);
        pulse_reti();
        check("reti_holdoff0", {15'd0, INT_REQ}, 16'd0);
        expect_quiet("reti_holdoff1", 1);
        wait_req("retake_t0", 16'h000B);
        flags[1] = 1'b0;
        step();
        check("flag_drop", {15'd0, INT_REQ}, 16'd0);

        // All four low-level flags together: fixed order.
        sfr_write(8'hA8, 8'h8F);
        flags = 4'hF;
        wait_req("order0", 16'h0003); service(0, 1'b1);
        wait_req("order1", 16'h000B); service(1, 1'b1);
        wait_req("order2", 16'h0013); service(2, 1'b1);
        wait_req("order3", 16'h001B); service(3, 1'b1);

        // Re-arbitration in PEND: EXT0 overtakes a pending TIMR1.
        flags[3] = 1'b1;
        wait_req("rearb_t1", 16'h001B);
        flags[0] = 1'b1;
        push_ev(1'b0, 16'h0003);
        step();
        step();
        service(0, 1'b1);
        wait_req("rearb_back", 16'h001B);
        service(3, 1'b1);

        // Preemption: high TIMR1 inside low EXT0 ISR; EXT1 waits for two RETIs.
        sfr_write(8'hB8, 8'h08);
        flags[0] = 1'b1;
        wait_req("pre_ext0", 16'h0003);
        service(0, 1'b0);
        flags[3] = 1'b1;
        flags[2] = 1'b1;
        wait_req("preempt_t1", 16'h001B);
        service(3, 1'b0);
        expect_quiet("blocked_hi", 5);
        pulse_reti();
        expect_quiet("blocked_lo", 5);
        pulse_reti();
        wait_req("ext1_after_reti", 16'h0013);
        service(2, 1'b1);

        // IS_HI blocks a low EXT0 until RETI and holdoff.
        sfr_write(8'hB8, 8'h02);
        flags[1] = 1'b1;
        wait_req("hi_t0", 16'h000B);
        service(1, 1'b0);
        flags[0] = 1'b1;
        expect_quiet("hi_blocks_lo", 4);
        pulse_reti();
        expect_quiet("reti_holdoff", 2);
        wait_req("ext0_after_reti", 16'h0003);
        service(0, 1'b1);
        sfr_write(8'hB8, 8'h00);

        // Mask changes: clearing IE[2] cancels a pending request, EA=0 masks all.
        flags[2] = 1'b1;
        wait_req("mask_ext1", 16'h0013);
        sfr_write(8'hA8, 8'h8B);
        check("ie_clear_drop", {15'd0, INT_REQ}, 16'd0);
        sfr_write(8'hA8, 8'h0F);
        expect_quiet("ea_mask", 6);
        flags[2] = 1'b0;

`ifdef IRQ_SERIAL_EN
        sfr_write(8'hA8, 8'h90);
        ser_flag = 1'b1;
        wait_req("serial", 16'h0023);
        take(4'd0);
        ser_flag = 1'b0;
        step();
        pulse_reti();
`endif

        // Reset during the ACK cycle suppresses the IACK pulse and clears the SFRs.
        sfr_write(8'hA8, 8'h82);
        flags[1] = 1'b1;
        wait_req("pre_reset", 16'h000B);
        INT_TAKEN = 1'b1;
        step();
        INT_TAKEN = 1'b0;
        RESET_N = 1'b0;
        #1 check("iack_in_reset", {15'd0, IACK_TIMR0}, 16'd0);
        step();
        RESET_N = 1'b1;
        flags[1] = 1'b0;
        read_check("post_rst_ie", 8'hA8, 8'h00);
        read_check("post_rst_ip", 8'hB8, 8'h00);
        check("post_rst_req", {15'd0, INT_REQ}, 16'd0);
        check("post_rst_vec", INT_VECTOR, 16'h0000);

        sfr_write(8'hA8, 8'h81);
        flags[0] = 1'b1;
        wait_req("recover", 16'h0003);
        service(0, 1'b1);

        repeat (4) step();
        check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
